// File: rtl/diff_decode_if.sv
// Sample-stream bus between the MSK demodulator and the differential decoder.
// Carries the hard-decision input, resync control and the decoded bit strobe.
interface diff_decode_if #(
  parameter int SPS = 32
);
  localparam int CW = $clog2(SPS);

  logic          din;
  logic          resync_en;
  logic          dout;
  logic          dvalid;
  logic [CW-1:0] sym_phase;

  modport master (
    output din,
    output resync_en,
    input  dout,
    input  dvalid,
    input  sym_phase
  );

  modport slave (
    input  din,
    input  resync_en,
    output dout,
    output dvalid,
    output sym_phase
  );
endinterface

// File: rtl/diff_decode.sv
// MSK receive differential decoder: transition-driven symbol timing,
// windowed majority vote per symbol, then dout = bit(n) ^ bit(n-1).
module diff_decode #(
  parameter int SPS    = 32,
  parameter int WIN_LO = 12,
  parameter int WIN_HI = 19,
  parameter int THRESH = 5
) (
  input  logic         clk,
  input  logic         rst,
  diff_decode_if.slave bus
);
  localparam int CW = $clog2(SPS);
  localparam int WL = WIN_HI - WIN_LO + 1;
  localparam int OW = $clog2(WL + 1);

  localparam logic [CW-1:0] LO   = CW'(WIN_LO);
  localparam logic [CW-1:0] HI   = CW'(WIN_HI);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic [OW-1:0] TH   = OW'(THRESH);

  logic          d1_q, d2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          ref_q, ref_d;
  logic          dout_q, dout_d;
  logic          dvalid_q, dvalid_d;

  logic edge_w, load, in_win, decide, bit_w;

  assign edge_w = d1_q ^ d2_q;
  assign load   = bus.resync_en & edge_w;
  assign in_win = (cnt_q >= LO) && (cnt_q <= HI);
  // A resync load on the last phase drops that symbol
  assign decide = (cnt_q == LAST) && !load;
  assign bit_w  = (ones_q >= TH);

  always_comb begin
    cnt_d    = load ? CW'(1) : cnt_q + CW'(1);
    ones_d   = ones_q;
    ref_d    = ref_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (load || cnt_q == '0) begin
      ones_d = '0;
    end else if (in_win) begin
      ones_d = ones_q + OW'(d2_q);
    end
    if (decide) begin
      ref_d    = bit_w;
      dout_d   = bit_w ^ ref_q;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1_q     <= 1'b0;
      d2_q     <= 1'b0;
      cnt_q    <= '0;
      ones_q   <= '0;
      ref_q    <= 1'b0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      d1_q     <= bus.din;
      d2_q     <= d1_q;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      ref_q    <= ref_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.sym_phase = cnt_q;
endmodule

// File: tb/tb_diff_decode.sv
// Directed bench for diff_decode: loopback, noise, acquisition,
// resync-off glitch, mid-symbol reset and a long constant run.
module tb_diff_decode;
  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   last_s0;
  int   t0;

  logic dq[$];
  int   tq[$];

  diff_decode_if #(.SPS(32)) bus ();

  diff_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dvalid === 1'b1) begin
      dq.push_back(bus.dout);
      tq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    dq.delete();
    tq.delete();
  endtask

  task automatic do_reset(input string tag);
    bus.din = 1'b0;
    rst     = 1'b0;
    #1;
    chk({tag, "_dout"}, 32'(bus.dout), 0);
    chk({tag, "_dvalid"}, 32'(bus.dvalid), 0);
    chk({tag, "_phase"}, 32'(bus.sym_phase), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_dvalid"}, 32'(bus.dvalid), 0);
      chk({tag, "_hold_phase"}, 32'(bus.sym_phase), 0);
    end
    rst = 1'b1;
  endtask

  // Sample k of the pattern is driven on bit k; after its capture edge an
  // aligned decoder reports sym_phase == k.
  task automatic send_sym(input logic [31:0] pat, input int chk_k);
    for (int k = 0; k < 32; k++) begin
      bus.din = pat[k];
      @(posedge clk);
      #1;
      if (k == 0) last_s0 = cyc;
      if (k == chk_k) chk("phase", 32'(bus.sym_phase), 32'(k));
    end
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      bus.din = b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_q(input string tag, input int n,
                         input logic [63:0] exp);
    chk({tag, "_count"}, 32'(dq.size()), 32'(n));
    for (int i = 0; i < dq.size() && i < n; i++) begin
      chk({tag, "_dout"}, 32'(dq[i]), 32'(exp[i]));
      if (i > 0) chk({tag, "_gap"}, 32'(tq[i] - tq[i-1]), 32);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    cyc           = 0;
    last_s0       = 0;
    bus.din       = 1'b0;
    bus.resync_en = 1'b1;
    rst           = 1'b0;
    @(negedge clk);

    // encoded 1,1,0,1,1,1,0 -> decoded 1,0,1,1,0,0,1
    do_reset("rst0");
    clr_q();
    send_sym(32'hFFFF_FFFF, -1);
    send_sym(32'hFFFF_FFFF, -1);
    send_sym(32'h0000_0000, -1);
    send_sym(32'hFFFF_FFFF, -1);
    send_sym(32'hFFFF_FFFF, -1);
    send_sym(32'hFFFF_FFFF, -1);
    send_sym(32'h0000_0000, -1);
    idle(4, 1'b0);
    check_q("loop", 7, 64'd77);

    // ones=5 -> bit 1 ; ones=4 -> bit 0
    do_reset("rst1");
    clr_q();
    send_sym(32'hFFFF_FFFF, -1);
    bus.resync_en = 1'b0;
    send_sym(32'hFFFF_57FF, -1);
    send_sym(32'hFFFD_57FF, -1);
    send_sym(32'hFFFF_FFFF, -1);
    idle(4, 1'b1);
    check_q("noise", 4, 64'd13);

    // first edge 10 samples in; encoded 1,0,0,1 -> 1,1,0,1
    bus.resync_en = 1'b1;
    do_reset("rst2");
    clr_q();
    idle(10, 1'b0);
    send_sym(32'hFFFF_FFFF, 1);
    t0 = last_s0;
    send_sym(32'h0000_0000, -1);
    send_sym(32'h0000_0000, -1);
    send_sym(32'hFFFF_FFFF, -1);
    idle(4, 1'b1);
    check_q("acq", 4, 64'd11);
    if (tq.size() > 0) chk("acq_latency", 32'(tq[0] - t0), 32);

    // glitch at sample 25 must not disturb timing
    do_reset("rst3");
    clr_q();
    send_sym(32'hFFFF_FFFF, -1);
    bus.resync_en = 1'b0;
    send_sym(32'hFDFF_FFFF, 27);
    send_sym(32'h0000_0000, -1);
    send_sym(32'h0000_0000, -1);
    idle(4, 1'b0);
    check_q("nores", 4, 64'd5);

    // reset at phase 15 of the second symbol
    bus.resync_en = 1'b1;
    do_reset("rst4");
    clr_q();
    send_sym(32'hFFFF_FFFF, -1);
    for (int k = 0; k < 16; k++) begin
      bus.din = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_phase", 32'(bus.sym_phase), 15);
    chk("pre_rst_dout", 32'(bus.dout), 1);
    do_reset("midrst");
    clr_q();
    send_sym(32'hFFFF_FFFF, -1);
    idle(4, 1'b1);
    check_q("postrst", 1, 64'd1);

    // 64 zero symbols, no edges
    do_reset("rst5");
    clr_q();
    repeat (64) send_sym(32'h0000_0000, -1);
    idle(4, 1'b0);
    check_q("long", 64, 64'd0);
    chk("long_phase", 32'(bus.sym_phase), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
